mic_mem_responder: RTL

MIC_MEM_RESPONDER -- requirements
Module: mic_mem_responder

---
 rtl/mic_mem_if.sv | 46 ++++
 rtl/mic_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mic_mem_if.sv
// Command/response bus between a memory requestor and mic_mem_responder.
// The master issues read/write commands; the slave returns tagged read data.
interface mic_mem_if #(
  parameter int unsigned NREQS  = 1,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic              cntrl_memory_read;
  logic              cntrl_memory_write;
  logic [NREQS-1:0]  cntrl_memory_read_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;
  logic [NREQS-1:0]  mem_rdata_tag;
  logic              mem_err;

  modport master (
    output cntrl_memory_read,
    output cntrl_memory_write,
    output cntrl_memory_read_valid,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata,
    input  mem_rdata_valid,
    input  mem_rdata_tag,
    input  mem_err
  );

  modport slave (
    input  cntrl_memory_read,
    input  cntrl_memory_write,
    input  cntrl_memory_read_valid,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata,
    output mem_rdata_valid,
    output mem_rdata_tag,
    output mem_err
  );

endinterface

// File: rtl/mic_mem_responder.sv
// Single-port memory responder with pipelined, tagged reads.
// After reset the array is cleared one word per cycle (INIT), then commands
// are accepted (READY). Illegal commands are dropped and raise a sticky error.
// Optional feature: define MIC_RESP_STATS_EN to add saturating stat_reads /
// stat_writes counters of accepted commands.
module mic_mem_responder #(
  parameter int unsigned NREQS        = 1,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  mic_mem_if.slave    bus
`ifdef MIC_RESP_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("mic_mem_responder: READ_LATENCY must be 1..4");
  end

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_done_q;
  logic              ready_q;
  logic              err_q;

  logic [DATA_W-1:0] mem_q [Depth];

  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [DATA_W-1:0]       pipe_data_q [READ_LATENCY];
  logic [NREQS-1:0]        pipe_tag_q  [READ_LATENCY];

  logic rd;
  logic wr;
  logic tag_onehot;
  logic in_ready;
  logic rd_accept;
  logic wr_accept;
  logic cmd_err;

  // Command decode: classify the current command as accepted or erroneous.
  always_comb begin
    rd         = bus.cntrl_memory_read;
    wr         = bus.cntrl_memory_write;
    tag_onehot = $onehot(bus.cntrl_memory_read_valid);
    in_ready   = (state_q == StReady);
    rd_accept  = in_ready & rd & ~wr & tag_onehot;
    wr_accept  = in_ready & wr & ~rd;
    // Any command outside READY, a read+write collision, or a bad read tag.
    cmd_err    = (rd | wr) & (~in_ready | (rd & wr) | (rd & ~tag_onehot));
  end

  // FSM: sweep the clear counter over every address, then park in READY.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (init_done_q) begin
            // Last word was cleared in the previous cycle.
            state_q <= StReady;
            ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == ADDR_W'(Depth - 1)) begin
              init_done_q <= 1'b1;
            end
          end
        end
        StReady: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StInit;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: cleared word-by-word during INIT, written by accepted writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == StInit && !init_done_q) begin
        mem_q[init_cnt_q] <= '0;
      end else if (wr_accept) begin
        mem_q[bus.mem_addr] <= bus.mem_wdata;
      end
    end
  end

  // Read pipeline: stage 0 samples the array, later stages delay by one cycle.
  // Data and tag are forced to zero in empty slots so the outputs stay quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe_data_q[i] <= '0;
        pipe_tag_q[i]  <= '0;
      end
    end else begin
      pipe_valid_q[0] <= rd_accept;
      pipe_data_q[0]  <= rd_accept ? mem_q[bus.mem_addr] : '0;
      pipe_tag_q[0]   <= rd_accept ? bus.cntrl_memory_read_valid : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
        pipe_tag_q[i]   <= pipe_tag_q[i-1];
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cmd_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mem_ready       = ready_q;
  assign bus.mem_rdata_valid = pipe_valid_q[READ_LATENCY-1];
  assign bus.mem_rdata       = pipe_data_q[READ_LATENCY-1];
  assign bus.mem_rdata_tag   = pipe_tag_q[READ_LATENCY-1];
  assign bus.mem_err         = err_q;

`ifdef MIC_RESP_STATS_EN
  logic [15:0] stat_reads_q;
  logic [15:0] stat_writes_q;

  // Saturating counts of accepted reads and writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      if (rd_accept && stat_reads_q != 16'hFFFF) begin
        stat_reads_q <= stat_reads_q + 16'd1;
      end
      if (wr_accept && stat_writes_q != 16'hFFFF) begin
        stat_writes_q <= stat_writes_q + 16'd1;
      end
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule
